// File: rtl/scan_config_loader.sv
// scan_config_loader: streams host config words LSB-first onto a fabric scan chain (CE/SIN).
// Define CFG_READBACK_EN to also capture CFG_SOUT into host-width words on RB_DATA/RB_VALID.
module scan_config_loader #(
  parameter int CHAIN_LEN = 512,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              CFG_CE,
  output logic              CFG_SIN,
  input  logic              CFG_SOUT,
  output logic              BUSY,
  output logic              DONE
`ifdef CFG_READBACK_EN
  ,
  output logic [DATA_W-1:0] RB_DATA,
  output logic              RB_VALID
`endif
);

  localparam int SH_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] WORDS      = CNT_W'((CHAIN_LEN + DATA_W - 1) / DATA_W);
  localparam logic [CNT_W-1:0] CHAIN_BITS = CNT_W'(CHAIN_LEN);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  bits_q, bits_d;
  logic              ce_q, ce_d;
  logic              sin_q, sin_d;
  logic              busy;
  logic              in_ready;
  logic              accept;

  assign busy     = (state_q != S_IDLE);
  assign in_ready = busy & ~hold_full_q & (acc_q < WORDS);
  assign accept   = IN_VALID & in_ready;

  assign IN_READY = in_ready;
  assign CFG_CE   = ce_q;
  assign CFG_SIN  = sin_q;
  assign BUSY     = busy;
  assign DONE     = (state_q == S_FINISH);

  // Bit source priority: shift register, then holding register, then the word arriving now.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    sh_cnt_d    = sh_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    acc_d       = acc_q;
    bits_d      = bits_q;
    ce_d        = 1'b0;
    sin_d       = sin_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d     = S_FILL;
          acc_d       = '0;
          bits_d      = '0;
          sh_cnt_d    = '0;
          hold_full_d = 1'b0;
        end
      end

      S_FILL, S_SHIFT: begin
        if (accept) begin
          acc_d = acc_q + 1'b1;
        end
        if (bits_q < CHAIN_BITS) begin
          if (sh_cnt_q != '0) begin
            ce_d     = 1'b1;
            sin_d    = shift_q[0];
            shift_d  = shift_q >> 1;
            sh_cnt_d = sh_cnt_q - 1'b1;
            if (accept) begin
              hold_d      = IN_DATA;
              hold_full_d = 1'b1;
            end
          end else if (hold_full_q) begin
            ce_d        = 1'b1;
            sin_d       = hold_q[0];
            shift_d     = hold_q >> 1;
            sh_cnt_d    = SH_W'(DATA_W - 1);
            hold_full_d = 1'b0;
          end else if (accept) begin
            ce_d     = 1'b1;
            sin_d    = IN_DATA[0];
            shift_d  = IN_DATA >> 1;
            sh_cnt_d = SH_W'(DATA_W - 1);
          end
          if (ce_d) begin
            bits_d = bits_q + 1'b1;
          end
          if ((state_q == S_FILL) && accept) begin
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_FINISH;
        end
      end

      default: begin
        // Leftover upper bits of a partial last word are dropped here.
        state_d     = S_IDLE;
        sh_cnt_d    = '0;
        hold_full_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      sh_cnt_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      acc_q       <= '0;
      bits_q      <= '0;
      ce_q        <= 1'b0;
      sin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      sh_cnt_q    <= sh_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      acc_q       <= acc_d;
      bits_q      <= bits_d;
      ce_q        <= ce_d;
      sin_q       <= sin_d;
    end
  end

`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0] rb_word_q, rb_word_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic [DATA_W-1:0] rb_next;
  logic [SH_W-1:0]   rb_cnt_q, rb_cnt_d;
  logic              rb_valid_q, rb_valid_d;

  // SOUT is sampled while CE is high, i.e. before the edge that shifts it away.
  always_comb begin
    rb_word_d  = rb_word_q;
    rb_data_d  = rb_data_q;
    rb_cnt_d   = rb_cnt_q;
    rb_valid_d = 1'b0;
    rb_next    = rb_word_q | (DATA_W'(CFG_SOUT) << rb_cnt_q);
    if ((state_q == S_IDLE) && START) begin
      rb_word_d = '0;
      rb_cnt_d  = '0;
    end else if (ce_q) begin
      if ((rb_cnt_q == SH_W'(DATA_W - 1)) || (bits_q == CHAIN_BITS)) begin
        rb_data_d  = rb_next;
        rb_valid_d = 1'b1;
        rb_word_d  = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_word_d = rb_next;
        rb_cnt_d  = rb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rb_word_q  <= '0;
      rb_data_q  <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_word_q  <= rb_word_d;
      rb_data_q  <= rb_data_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign RB_DATA  = rb_data_q;
  assign RB_VALID = rb_valid_q;
`else
  logic unused_sout;
  assign unused_sout = CFG_SOUT;
`endif

endmodule
